// File: rtl/warmboot_sequencer_if.sv
// Bundle between the bootloader and warmboot sequencer: boot request,
// image select, USB transmit activity in; pull-up and SB_WARMBOOT controls out.
interface warmboot_sequencer_if;
    logic       boot_req;
    logic [1:0] image_sel;
    logic       image_sel_valid;
    logic       usb_tx_en;
    logic       usb_pu;
    logic       wb_s1;
    logic       wb_s0;
    logic       wb_boot;
    logic       busy;

    // Bootloader side: issues the request, observes the sequencer
    modport master (
        output boot_req,
        output image_sel,
        output image_sel_valid,
        output usb_tx_en,
        input  usb_pu,
        input  wb_s1,
        input  wb_s0,
        input  wb_boot,
        input  busy
    );

    // Sequencer side
    modport slave (
        input  boot_req,
        input  image_sel,
        input  image_sel_valid,
        input  usb_tx_en,
        output usb_pu,
        output wb_s1,
        output wb_s0,
        output wb_boot,
        output busy
    );
endinterface

// File: rtl/warmboot_sequencer.sv
// Warmboot hand-off sequencer: waits for USB quiet, detaches the D+ pull-up,
// then presents the image select and fires SB_WARMBOOT.BOOT.
module warmboot_sequencer #(
    parameter int unsigned IDLE_CYCLES   = 4800,
    parameter int unsigned DETACH_CYCLES = 480000,
    parameter logic [1:0]  DEFAULT_IMAGE = 2'b01
) (
    input  logic                 clk_48mhz,
    input  logic                 reset,
    warmboot_sequencer_if.slave  bus
);

    localparam int unsigned MAX_CYCLES = (IDLE_CYCLES > DETACH_CYCLES) ? IDLE_CYCLES : DETACH_CYCLES;
    localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);
    localparam logic [CNT_W-1:0] IDLE_LAST   = CNT_W'(IDLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] DETACH_LAST = CNT_W'(DETACH_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DRAIN  = 2'd1,
        S_DETACH = 2'd2,
        S_FIRE   = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       image_q, image_d;
    logic             usb_pu_q, usb_pu_d;
    logic [1:0]       wb_s_q, wb_s_d;
    logic             wb_boot_q, wb_boot_d;
    logic             busy_q, busy_d;

    // State, counter, latched image and output registers
    always_ff @(posedge clk_48mhz) begin
        if (reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            image_q   <= 2'b00;
            usb_pu_q  <= 1'b1;
            wb_s_q    <= 2'b00;
            wb_boot_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            image_q   <= image_d;
            usb_pu_q  <= usb_pu_d;
            wb_s_q    <= wb_s_d;
            wb_boot_q <= wb_boot_d;
            busy_q    <= busy_d;
        end
    end

    // Next-state, shared counter and image latch; outputs decoded from registered state
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        image_d   = image_q;
        usb_pu_d  = 1'b1;
        wb_s_d    = 2'b00;
        wb_boot_d = 1'b0;
        busy_d    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.boot_req) begin
                    image_d = bus.image_sel_valid ? bus.image_sel : DEFAULT_IMAGE;
                    state_d = S_DRAIN;
                    cnt_d   = '0;
                end
            end
            S_DRAIN: begin
                // Any transmit activity restarts the quiet window
                if (bus.usb_tx_en) begin
                    cnt_d = '0;
                end else if (cnt_q == IDLE_LAST) begin
                    state_d = S_DETACH;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DETACH: begin
                if (cnt_q == DETACH_LAST) begin
                    state_d = S_FIRE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_FIRE: begin
                state_d = S_FIRE;
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase

        usb_pu_d  = (state_q == S_IDLE) || (state_q == S_DRAIN);
        wb_boot_d = (state_q == S_FIRE);
        busy_d    = (state_q != S_IDLE);
        wb_s_d    = (state_q == S_IDLE) ? 2'b00 : image_q;
    end

    assign bus.usb_pu  = usb_pu_q;
    assign bus.wb_s1   = wb_s_q[1];
    assign bus.wb_s0   = wb_s_q[0];
    assign bus.wb_boot = wb_boot_q;
    assign bus.busy    = busy_q;

endmodule
